// File: rtl/pipe_elastic_if.sv
// Handshake bundle for pipe_elastic: upstream beat, downstream beat, flush and occupancy.
// The slave modport is the pipeline itself; master is whoever drives and consumes it.
interface pipe_elastic_if #(
    parameter int WIDTH = 32,
    parameter int N     = 2
);
    localparam int CW = $clog2(N + 1);

    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic [CW-1:0]    o_count;

    modport master (
        output i_flush, i_valid, i_data, i_ready,
        input  o_ready, o_valid, o_data, o_count
    );

    modport slave (
        input  i_flush, i_valid, i_data, i_ready,
        output o_ready, o_valid, o_data, o_count
    );
endinterface

// File: rtl/pipe_elastic.sv
// N-stage WIDTH-bit elastic pipeline: valid/ready on both sides, bubble collapsing,
// synchronous flush and a registered occupancy counter.
module pipe_elastic #(
    parameter int WIDTH     = 32,
    parameter int N         = 2,
    parameter int WithReset = 0
) (
    input  logic          clk,
    input  logic          reset,
    pipe_elastic_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    logic [N-1:0]     vld_r;
    logic [WIDTH-1:0] dat_r [N];
    logic [CW-1:0]    count_r;

    logic [N-1:0]     rdy_s;
    logic [N-1:0]     vin_s;
    logic [WIDTH-1:0] din_s [N];
    logic             in_xfer_s;
    logic             out_xfer_s;

    // Stage k is ready when any stage from k to the output is empty or the sink accepts.
    always_comb begin : rdy_chain
        logic acc;
        acc = bus.i_ready;
        for (int k = N - 1; k >= 0; k--) begin
            acc      = acc | ~vld_r[k];
            rdy_s[k] = acc;
        end
    end

    // Source of each stage: upstream port for stage 0, previous stage otherwise.
    always_comb begin
        vin_s[0] = bus.i_valid;
        din_s[0] = bus.i_data;
        for (int k = 1; k < N; k++) begin
            vin_s[k] = vld_r[k-1];
            din_s[k] = dat_r[k-1];
        end
    end

    // The pipeline must not look ready while it is being held in reset.
    assign bus.o_ready = rdy_s[0] & ~reset;
    assign in_xfer_s   = bus.i_valid & bus.o_ready;
    assign out_xfer_s  = vld_r[N-1] & bus.i_ready;

    // Stage valids and occupancy; flush discards everything, including a beat accepted this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_r   <= '0;
            count_r <= '0;
        end else if (bus.i_flush) begin
            vld_r   <= '0;
            count_r <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (rdy_s[k]) begin
                    vld_r[k] <= vin_s[k];
                end
            end
            count_r <= count_r + CW'(in_xfer_s) - CW'(out_xfer_s);
        end
    end

    generate
        if (WithReset != 0) begin : g_dat_rst
            // Data stages with reset; a register only loads when a real beat moves into it.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < N; k++) begin
                        dat_r[k] <= '0;
                    end
                end else begin
                    for (int k = 0; k < N; k++) begin
                        if (rdy_s[k] & vin_s[k]) begin
                            dat_r[k] <= din_s[k];
                        end
                    end
                end
            end
        end else begin : g_dat_norst
            // Data stages without reset; bubbles never toggle the data registers.
            always_ff @(posedge clk) begin
                for (int k = 0; k < N; k++) begin
                    if (rdy_s[k] & vin_s[k]) begin
                        dat_r[k] <= din_s[k];
                    end
                end
            end
        end
    endgenerate

    assign bus.o_valid = vld_r[N-1];
    assign bus.o_data  = dat_r[N-1];
    assign bus.o_count = count_r;
endmodule

// File: tb/tb_pipe_elastic.sv
// Directed bench for pipe_elastic: a 3-stage instance with data reset and a 4-stage one without.
module tb_pipe_elastic;
    logic clk;
    logic reset;
    int   n_assert;
    int   n_fail;

    pipe_elastic_if #(.WIDTH(8), .N(3)) bus3 ();
    pipe_elastic_if #(.WIDTH(8), .N(4)) bus4 ();

    pipe_elastic #(.WIDTH(8), .N(3), .WithReset(1)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
    pipe_elastic #(.WIDTH(8), .N(4), .WithReset(0)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b1;
        bus3.i_flush = 1'b0; bus3.i_valid = 1'b0; bus3.i_data = 8'h00; bus3.i_ready = 1'b0;
        bus4.i_flush = 1'b0; bus4.i_valid = 1'b0; bus4.i_data = 8'h00; bus4.i_ready = 1'b0;
        #2;
        chk("rst_valid3", 32'(bus3.o_valid), 32'd0);
        chk("rst_count3", 32'(bus3.o_count), 32'd0);
        chk("rst_ready3", 32'(bus3.o_ready), 32'd0);
        chk("rst_data3",  32'(bus3.o_data),  32'd0);
        chk("rst_ready4", 32'(bus4.o_ready), 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        chk("rel_ready3", 32'(bus3.o_ready), 32'd1);
        chk("rel_ready4", 32'(bus4.o_ready), 32'd1);

        // single beat latency through empty 3-stage pipe
        bus3.i_ready = 1'b1;
        bus3.i_valid = 1'b1; bus3.i_data = 8'h11;
        #1;
        chk("t1_ready", 32'(bus3.o_ready), 32'd1);
        cyc();
        bus3.i_valid = 1'b0;
        chk("t1_c1_count", 32'(bus3.o_count), 32'd1);
        chk("t1_c1_valid", 32'(bus3.o_valid), 32'd0);
        cyc();
        chk("t1_c2_count", 32'(bus3.o_count), 32'd1);
        chk("t1_c2_valid", 32'(bus3.o_valid), 32'd0);
        cyc();
        chk("t1_c3_count", 32'(bus3.o_count), 32'd1);
        chk("t1_c3_valid", 32'(bus3.o_valid), 32'd1);
        chk("t1_c3_data",  32'(bus3.o_data),  32'h11);
        cyc();
        chk("t1_c4_count", 32'(bus3.o_count), 32'd0);
        chk("t1_c4_valid", 32'(bus3.o_valid), 32'd0);

        // continuous stream 0x01..0x0A
        for (int i = 0; i < 13; i++) begin
            bus3.i_valid = (i < 10);
            bus3.i_data  = 8'(i + 1);
            #1;
            chk("t2_ready", 32'(bus3.o_ready), 32'd1);
            cyc();
            if (i >= 2 && i < 12) begin
                chk("t2_valid", 32'(bus3.o_valid), 32'd1);
                chk("t2_data",  32'(bus3.o_data),  32'(i - 1));
            end else begin
                chk("t2_idle", 32'(bus3.o_valid), 32'd0);
            end
        end
        chk("t2_count_end", 32'(bus3.o_count), 32'd0);

        // back-pressure: fill, stall, then drain
        bus3.i_ready = 1'b0;
        bus3.i_valid = 1'b1; bus3.i_data = 8'h0A;
        cyc();
        bus3.i_data = 8'h0B;
        cyc();
        bus3.i_data = 8'h0C;
        cyc();
        chk("t3_full_count", 32'(bus3.o_count), 32'd3);
        chk("t3_full_data",  32'(bus3.o_data),  32'h0A);
        bus3.i_data = 8'h0D;
        #1;
        chk("t3_not_ready", 32'(bus3.o_ready), 32'd0);
        cyc();
        chk("t3_hold_count", 32'(bus3.o_count), 32'd3);
        chk("t3_hold_data",  32'(bus3.o_data),  32'h0A);
        chk("t3_hold_valid", 32'(bus3.o_valid), 32'd1);
        bus3.i_ready = 1'b1;
        #1;
        chk("t3_ready_again", 32'(bus3.o_ready), 32'd1);
        cyc();
        bus3.i_valid = 1'b0;
        chk("t3_out_b", 32'(bus3.o_data),  32'h0B);
        chk("t3_cnt_b", 32'(bus3.o_count), 32'd3);
        cyc();
        chk("t3_out_c", 32'(bus3.o_data),  32'h0C);
        chk("t3_cnt_c", 32'(bus3.o_count), 32'd2);
        cyc();
        chk("t3_out_d", 32'(bus3.o_data),  32'h0D);
        chk("t3_cnt_d", 32'(bus3.o_count), 32'd1);
        cyc();
        chk("t3_empty", 32'(bus3.o_valid), 32'd0);
        chk("t3_cnt_0", 32'(bus3.o_count), 32'd0);

        // 4-stage: gapped fill under stall, bubbles collapse
        bus4.i_ready = 1'b0;
        bus4.i_valid = 1'b1; bus4.i_data = 8'h21;
        cyc();
        bus4.i_valid = 1'b0;
        cyc();
        bus4.i_valid = 1'b1; bus4.i_data = 8'h22;
        cyc();
        bus4.i_valid = 1'b0;
        cyc();
        chk("t4_cnt2",  32'(bus4.o_count), 32'd2);
        chk("t4_head",  32'(bus4.o_data),  32'h21);
        bus4.i_valid = 1'b1; bus4.i_data = 8'h23;
        #1;
        chk("t4_ready_bubble", 32'(bus4.o_ready), 32'd1);
        cyc();
        bus4.i_data = 8'h24;
        #1;
        chk("t4_ready_bubble2", 32'(bus4.o_ready), 32'd1);
        cyc();
        bus4.i_data = 8'h25;
        #1;
        chk("t4_full",   32'(bus4.o_ready), 32'd0);
        chk("t4_cnt4",   32'(bus4.o_count), 32'd4);
        chk("t4_head2",  32'(bus4.o_data),  32'h21);
        bus4.i_valid = 1'b0;
        bus4.i_ready = 1'b1;
        cyc();
        chk("t4_out22", 32'(bus4.o_data),  32'h22);
        chk("t4_cnt3",  32'(bus4.o_count), 32'd3);
        cyc();
        chk("t4_out23", 32'(bus4.o_data),  32'h23);
        cyc();
        chk("t4_out24", 32'(bus4.o_data),  32'h24);
        chk("t4_cnt1",  32'(bus4.o_count), 32'd1);
        cyc();
        chk("t4_empty", 32'(bus4.o_valid), 32'd0);
        chk("t4_cnt0",  32'(bus4.o_count), 32'd0);

        // flush a full pipe while a new beat is handshaken
        bus3.i_ready = 1'b0;
        bus3.i_valid = 1'b1; bus3.i_data = 8'h01;
        cyc();
        bus3.i_data = 8'h02;
        cyc();
        bus3.i_data = 8'h03;
        cyc();
        chk("t5_full_count", 32'(bus3.o_count), 32'd3);
        bus3.i_flush = 1'b1;
        bus3.i_ready = 1'b1;
        bus3.i_data  = 8'hEE;
        #1;
        chk("t5_flush_ready", 32'(bus3.o_ready), 32'd1);
        cyc();
        bus3.i_flush = 1'b0;
        bus3.i_valid = 1'b0;
        chk("t5_count0", 32'(bus3.o_count), 32'd0);
        chk("t5_valid0", 32'(bus3.o_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t5_no_ee", 32'(bus3.o_valid), 32'd0);
        end

        // async reset mid-stream, then latency after release
        bus3.i_ready = 1'b1; bus4.i_ready = 1'b1;
        bus3.i_valid = 1'b1; bus3.i_data = 8'h31;
        bus4.i_valid = 1'b1; bus4.i_data = 8'h31;
        cyc();
        bus3.i_data = 8'h32; bus4.i_data = 8'h32;
        cyc();
        bus3.i_valid = 1'b0; bus4.i_valid = 1'b0;
        cyc();
        chk("t6_pre_valid", 32'(bus3.o_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_valid3", 32'(bus3.o_valid), 32'd0);
        chk("t6_rst_count3", 32'(bus3.o_count), 32'd0);
        chk("t6_rst_ready3", 32'(bus3.o_ready), 32'd0);
        chk("t6_rst_data3",  32'(bus3.o_data),  32'd0);
        chk("t6_rst_count4", 32'(bus4.o_count), 32'd0);
        cyc();
        chk("t6_rst_hold", 32'(bus3.o_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("t6_rel_ready3", 32'(bus3.o_ready), 32'd1);
        chk("t6_rel_ready4", 32'(bus4.o_ready), 32'd1);
        bus3.i_valid = 1'b1; bus3.i_data = 8'h55;
        bus4.i_valid = 1'b1; bus4.i_data = 8'h55;
        cyc();
        bus3.i_valid = 1'b0; bus4.i_valid = 1'b0;
        chk("t6_c1_valid3", 32'(bus3.o_valid), 32'd0);
        cyc();
        chk("t6_c2_valid3", 32'(bus3.o_valid), 32'd0);
        cyc();
        chk("t6_c3_valid3", 32'(bus3.o_valid), 32'd1);
        chk("t6_c3_data3",  32'(bus3.o_data),  32'h55);
        chk("t6_c3_valid4", 32'(bus4.o_valid), 32'd0);
        cyc();
        chk("t6_c4_valid4", 32'(bus4.o_valid), 32'd1);
        chk("t6_c4_data4",  32'(bus4.o_data),  32'h55);
        chk("t6_c4_valid3", 32'(bus3.o_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
